// File: rtl/stage_control.sv
// stage_control: game-level sequencer for the stage clear sweep, intermission wait and stage runs
module stage_control #(
    parameter int          FRAME_TICKS         = 1666667,
    parameter int          INTERMISSION_FRAMES = 60,
    parameter logic [8:0]  BG_COLOUR           = 9'h000
) (
    input  logic        Clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        stage_1_car_done,
    input  logic        stage_2_car_done,
    input  logic        stage_3_car_done,
    input  logic        game_over_feedback,
    output logic        stage_1_in_progress,
    output logic        stage_2_in_progress,
    output logic        stage_3_in_progress,
    output logic        clear_wren,
    output logic [14:0] clear_coord,
    output logic [8:0]  clear_colour,
    output logic [1:0]  current_stage,
    output logic        game_won,
    output logic        game_lost
);
    typedef enum logic [2:0] {IDLE, CLEAR, INTER, RUN1, RUN2, RUN3, WIN, LOSE} state_t;
    localparam logic [20:0] FRAME_LAST = 21'(FRAME_TICKS - 1);
    localparam logic [7:0]  TICK_LAST  = 8'(INTERMISSION_FRAMES - 1);
    state_t      state;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [20:0] frame;
    logic [7:0]  ticks;
    logic [1:0]  target;
    logic        frame_tick;
    logic        done;
    logic        last_pixel;
    state_t      run_state;
    assign frame_tick = frame == FRAME_LAST;
    assign last_pixel = x == 8'd159 && y == 7'd119;
    assign run_state  = target == 2'd1 ? RUN1 : target == 2'd2 ? RUN2 : RUN3;
    // only the done line of the stage currently running counts
    assign done = (state == RUN1 && stage_1_car_done) ||
                  (state == RUN2 && stage_2_car_done) ||
                  (state == RUN3 && stage_3_car_done);
    // sequencer state, sweep counters, frame counters and target stage
    always_ff @(posedge Clock) begin
        if (!resetn) begin
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            frame  <= '0;
            ticks  <= '0;
            target <= 2'd1;
        end else begin
            case (state)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        state  <= CLEAR;
                        target <= 2'd1;
                        x      <= '0;
                        y      <= '0;
                    end
                end
                CLEAR: begin
                    if (last_pixel) begin
                        state <= INTER;
                        x     <= '0;
                        y     <= '0;
                        frame <= '0;
                        ticks <= '0;
                    end else if (x == 8'd159) begin
                        x <= '0;
                        y <= y + 7'd1;
                    end else begin
                        x <= x + 8'd1;
                    end
                end
                INTER: begin
                    frame <= frame_tick ? '0 : frame + 21'd1;
                    if (frame_tick) ticks <= ticks + 8'd1;
                    if (frame_tick && ticks == TICK_LAST) state <= run_state;
                end
                RUN1, RUN2, RUN3: begin
                    if (game_over_feedback) begin
                        state <= LOSE;
                    end else if (done) begin
                        if (target == 2'd3) begin
                            state <= WIN;
                        end else begin
                            state  <= CLEAR;
                            target <= target + 2'd1;
                            x      <= '0;
                            y      <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign stage_1_in_progress = state == RUN1;
    assign stage_2_in_progress = state == RUN2;
    assign stage_3_in_progress = state == RUN3;
    assign clear_wren          = state == CLEAR;
    assign clear_coord         = clear_wren ? {x, y} : '0;
    assign clear_colour        = clear_wren ? BG_COLOUR : '0;
    assign current_stage       = state == IDLE ? 2'd0 : target;
    assign game_won            = state == WIN;
    assign game_lost           = state == LOSE;
endmodule
